ga_parent_selector: RTL

Elitist parent-selection controller for the genetic-algorithm core. On `start` it scans all 32 entries of the score RAM through that RAM's read port and finds the best and second-best scoring individuals. It then fetches their 48-bit genes through the gene RAM read port and presents them as `parent_a`/`parent_b` to the crossover/mutation stage, together with the total population fitness. It is the sole owner of both RAMs' read-address ports.

---
 rtl/ga_parent_selector.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ga_parent_selector.sv
// ga_parent_selector: elitist parent selection for the GA core.
// Scans the score RAM for the best and second-best individuals, fetches their
// genes from the gene RAM and publishes them with the population fitness sum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; working registers held cleared
// SCAN    | reading score RAM entry cnt, updating best/second/sum
// FETCH_A | reading gene of working best into parent A
// FETCH_B | reading gene of working second into parent B
// DONE    | publishing working values, pulsing done
module ga_parent_selector #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int SCORE_W = 7,
    parameter int GENE_W  = 48,
    parameter int SUM_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  score_rdaddr,
    input  logic [SCORE_W-1:0] score_rddata,
    output logic [ADDR_W-1:0]  gene_rdaddr,
    input  logic [GENE_W-1:0]  gene_rddata,
    output logic               result_valid,
    output logic [ADDR_W-1:0]  best_idx,
    output logic [ADDR_W-1:0]  second_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic [SCORE_W-1:0] second_score,
    output logic [GENE_W-1:0]  parent_a,
    output logic [GENE_W-1:0]  parent_b,
    output logic [SUM_W-1:0]   fitness_sum
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        FETCH_A = 3'd2,
        FETCH_B = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]  cnt;
    logic               wb_valid, ws_valid;
    logic [ADDR_W-1:0]  wb_idx, ws_idx;
    logic [SCORE_W-1:0] wb_score, ws_score;
    logic [SUM_W-1:0]   wsum;
    logic [GENE_W-1:0]  wpa, wpb;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and the RAM address / busy outputs derived from state.
    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        score_rdaddr = '0;
        gene_rdaddr  = '0;
        case (state)
            IDLE: begin
                if (start) state_nx = SCAN;
            end
            SCAN: begin
                busy         = 1'b1;
                score_rdaddr = cnt;
                if (cnt == ADDR_W'(DEPTH - 1)) state_nx = FETCH_A;
            end
            FETCH_A: begin
                busy        = 1'b1;
                gene_rdaddr = wb_idx;
                state_nx    = FETCH_B;
            end
            FETCH_B: begin
                busy        = 1'b1;
                gene_rdaddr = ws_idx;
                state_nx    = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working datapath and published results; results only move in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            wb_valid     <= 1'b0;
            ws_valid     <= 1'b0;
            wb_idx       <= '0;
            ws_idx       <= '0;
            wb_score     <= '0;
            ws_score     <= '0;
            wsum         <= '0;
            wpa          <= '0;
            wpb          <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            best_idx     <= '0;
            second_idx   <= '0;
            best_score   <= '0;
            second_score <= '0;
            parent_a     <= '0;
            parent_b     <= '0;
            fitness_sum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    wb_valid <= 1'b0;
                    ws_valid <= 1'b0;
                    wsum     <= '0;
                    if (start) result_valid <= 1'b0;
                end
                SCAN: begin
                    cnt  <= cnt + ADDR_W'(1);
                    wsum <= wsum + SUM_W'(score_rddata);
                    // Strict compares keep the lower index on ties.
                    if (!wb_valid || (score_rddata > wb_score)) begin
                        ws_valid <= wb_valid;
                        ws_idx   <= wb_idx;
                        ws_score <= wb_score;
                        wb_valid <= 1'b1;
                        wb_idx   <= cnt;
                        wb_score <= score_rddata;
                    end else if (!ws_valid || (score_rddata > ws_score)) begin
                        ws_valid <= 1'b1;
                        ws_idx   <= cnt;
                        ws_score <= score_rddata;
                    end
                end
                FETCH_A: wpa <= gene_rddata;
                FETCH_B: wpb <= gene_rddata;
                DONE: begin
                    best_idx     <= wb_idx;
                    second_idx   <= ws_idx;
                    best_score   <= wb_score;
                    second_score <= ws_score;
                    parent_a     <= wpa;
                    parent_b     <= wpb;
                    fitness_sum  <= wsum;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
